// File: rtl/img_frame_sequencer.sv
// Frame-level sequencer for the grey/Sobel datapath: pixel/line counters, frame-boundary mode commit, malformed line/frame flags.
// Optional build macro AUTO_CYCLE_EN: committed mode steps grey -> edge-horizontal -> edge-vertical every CYCLE_FRAMES frames.
module img_frame_sequencer #(
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480,
   parameter int WARMUP_LINES = 2,
   parameter int CYCLE_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iFVAL,
   input  logic        iLVAL,
   input  logic        iPIXV,
   input  logic        req_mode,
   input  logic        req_vertical,
   input  logic        err_clr,
   output logic [10:0] X_Cont,
   output logic [10:0] Y_Cont,
   output logic        oDVAL,
   output logic        mode_switch,
   output logic        is_vertical,
   output logic        edge_ready,
   output logic [15:0] frame_cnt,
   output logic        line_err,
   output logic        frame_err,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      SYNC       = 2'd0,
      WAIT_FRAME = 2'd1,
      ACTIVE     = 2'd2,
      FRAME_END  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_commit;
   logic        w_active;
   logic        w_frame_end;

   logic        r_fval_d;
   logic        r_lval_d;
   logic [10:0] r_x;
   logic [10:0] r_y;
   logic [11:0] r_pix_cnt;
   logic [10:0] r_x_cont;
   logic [10:0] r_y_cont;
   logic        r_dval;
   logic        r_mode;
   logic        r_vert;
   logic [15:0] r_frame_cnt;
   logic        r_line_err;
   logic        r_frame_err;

   logic        w_fval_rise;
   logic        w_fval_fall;
   logic        w_lval_fall;
   logic        w_pix;
   logic        w_line_end;
   logic        w_line_bad;
   logic        w_frame_bad;

   assign w_fval_rise = iFVAL & ~r_fval_d;
   assign w_fval_fall = ~iFVAL & r_fval_d;
   assign w_lval_fall = ~iLVAL & r_lval_d;
   assign w_pix       = w_active & iFVAL & iLVAL & iPIXV;
   assign w_line_end  = w_active & w_lval_fall;
   // Zero-pixel lines are neither counted nor flagged.
   assign w_line_bad  = w_line_end & (r_pix_cnt != 12'd0) & (r_pix_cnt != 12'(IMAGE_WIDTH));
   assign w_frame_bad = w_frame_end & (r_y != 11'(IMAGE_HEIGHT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_active    = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         SYNC: begin
            if (!iFVAL) w_state_nxt = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            if (w_fval_rise) begin
               w_commit    = 1'b1;
               w_state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            w_active = 1'b1;
            if (w_fval_fall) w_state_nxt = FRAME_END;
         end
         FRAME_END: begin
            w_frame_end = 1'b1;
            w_state_nxt = WAIT_FRAME;
         end
         default: w_state_nxt = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fval_d    <= 1'b0;
         r_lval_d    <= 1'b0;
         r_x         <= '0;
         r_y         <= '0;
         r_pix_cnt   <= '0;
         r_x_cont    <= '0;
         r_y_cont    <= '0;
         r_dval      <= 1'b0;
         r_frame_cnt <= '0;
         r_line_err  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_fval_d <= iFVAL;
         r_lval_d <= iLVAL;
         r_dval   <= w_pix;
         if (w_commit) begin
            r_x       <= '0;
            r_y       <= '0;
            r_pix_cnt <= '0;
            r_x_cont  <= '0;
            r_y_cont  <= '0;
         end else begin
            if (w_pix) begin
               r_x_cont <= r_x;
               r_y_cont <= r_y;
               r_x      <= (r_x == 11'(IMAGE_WIDTH - 1)) ? 11'd0 : r_x + 11'd1;
               if (r_pix_cnt != 12'hFFF) r_pix_cnt <= r_pix_cnt + 12'd1;
            end
            if (w_line_end) begin
               r_x       <= '0;
               r_pix_cnt <= '0;
               if ((r_pix_cnt != 12'd0) && (r_y != 11'd2047)) r_y <= r_y + 11'd1;
            end
         end
         if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
         // A new error event outranks a clear arriving in the same cycle.
         r_line_err  <= w_line_bad  | (r_line_err  & ~err_clr);
         r_frame_err <= w_frame_bad | (r_frame_err & ~err_clr);
      end
   end

`ifdef AUTO_CYCLE_EN
   logic [15:0] r_div;
   logic [1:0]  r_step;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div  <= '0;
         r_step <= '0;
         r_mode <= 1'b0;
         r_vert <= 1'b0;
      end else begin
         if (w_frame_end) begin
            if (r_div == 16'(CYCLE_FRAMES - 1)) begin
               r_div  <= '0;
               r_step <= (r_step == 2'd2) ? 2'd0 : r_step + 2'd1;
            end else begin
               r_div <= r_div + 16'd1;
            end
         end
         if (w_commit) begin
            r_mode <= (r_step != 2'd0);
            r_vert <= (r_step == 2'd2);
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode <= 1'b0;
         r_vert <= 1'b0;
      end else if (w_commit) begin
         r_mode <= req_mode;
         r_vert <= req_vertical;
      end
   end
`endif

   assign X_Cont      = r_x_cont;
   assign Y_Cont      = r_y_cont;
   assign oDVAL       = r_dval;
   assign mode_switch = r_mode;
   assign is_vertical = r_vert;
   assign edge_ready  = r_mode & (r_y_cont >= 11'(WARMUP_LINES));
   assign frame_cnt   = r_frame_cnt;
   assign line_err    = r_line_err;
   assign frame_err   = r_frame_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Directed bench for img_frame_sequencer on a reduced 16x8 image; pixel outputs are checked by a queue-based scoreboard.
`timescale 1ns/1ps
module tb_img_frame_sequencer;
   localparam int W    = 16;
   localparam int H    = 8;
   localparam int WARM = 2;
   localparam int CYC  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        iFVAL = 1'b0, iLVAL = 1'b0, iPIXV = 1'b0;
   logic        req_mode = 1'b0, req_vertical = 1'b0, err_clr = 1'b0;
   logic [10:0] X_Cont, Y_Cont;
   logic        oDVAL, mode_switch, is_vertical, edge_ready, line_err, frame_err;
   logic [15:0] frame_cnt;
   logic [1:0]  o_dbg_state;

   always #5 clk = ~clk;

   img_frame_sequencer #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .WARMUP_LINES(WARM), .CYCLE_FRAMES(CYC)
   ) dut (
      .clk(clk), .rst(rst), .iFVAL(iFVAL), .iLVAL(iLVAL), .iPIXV(iPIXV),
      .req_mode(req_mode), .req_vertical(req_vertical), .err_clr(err_clr),
      .X_Cont(X_Cont), .Y_Cont(Y_Cont), .oDVAL(oDVAL), .mode_switch(mode_switch),
      .is_vertical(is_vertical), .edge_ready(edge_ready), .frame_cnt(frame_cnt),
      .line_err(line_err), .frame_err(frame_err), .o_dbg_state(o_dbg_state)
   );

   // Scoreboard entry: {x[10:0], y[10:0], mode, vertical, edge_ready}
   logic [24:0] exp_q[$];
   logic [24:0] mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   int   exp_frames = 0;
   int   done_since_rst = 0;
   int   exp_y = 0;
   int   frame_lines = 0;
   logic exp_mode = 1'b0, exp_vert = 1'b0;
   logic exp_line_err = 1'b0, exp_frame_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && oDVAL) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_dval: got X=%0d Y=%0d expected no pixel at %0t", X_Cont, Y_Cont, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("pixel{x,y,mode,vert,edge_ready}",
                  {7'd0, X_Cont, Y_Cont, mode_switch, is_vertical, edge_ready}, {7'd0, mon_e});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame_start();
`ifdef AUTO_CYCLE_EN
      int step;
      step     = (done_since_rst / CYC) % 3;
      exp_mode = (step != 0);
      exp_vert = (step == 2);
`else
      exp_mode = req_mode;
      exp_vert = req_vertical;
`endif
      exp_y       = 0;
      frame_lines = 0;
      iFVAL       = 1'b1;
      tick(2);
   endtask

   task automatic line(input int npix, input bit gappy, input bit push,
                       input bit drop_fval, input bit clr_at_end);
      int sent = 0;
      int c = 0;
      iLVAL = 1'b1;
      iPIXV = 1'b0;
      if (npix == 0) tick(2);
      while (sent < npix) begin
         if (gappy && (c % 3 == 2)) begin
            iPIXV = 1'b0;
         end else begin
            iPIXV = 1'b1;
            if (push)
               exp_q.push_back({11'(sent % W), 11'(exp_y), exp_mode, exp_vert,
                                (exp_mode && (exp_y >= WARM))});
            sent++;
         end
         c++;
         tick(1);
      end
      iPIXV = 1'b0;
      iLVAL = 1'b0;
      if (drop_fval) iFVAL = 1'b0;
      if (clr_at_end) begin
         err_clr       = 1'b1;
         exp_line_err  = 1'b0;
         exp_frame_err = 1'b0;
      end
      if (npix > 0) begin
         frame_lines++;
         if (npix != W) exp_line_err = 1'b1;
         if (exp_y < 2047) exp_y++;
      end
      tick(1);
      err_clr = 1'b0;
      tick(1);
   endtask

   task automatic frame_end();
      iFVAL = 1'b0;
      tick(4);
      exp_frames++;
      done_since_rst++;
      if (frame_lines != H) exp_frame_err = 1'b1;
      check("frame_cnt", {16'd0, frame_cnt}, 32'(exp_frames % 65536));
      check("line_err", {31'd0, line_err}, {31'd0, exp_line_err});
      check("frame_err", {31'd0, frame_err}, {31'd0, exp_frame_err});
      check("mode_switch", {31'd0, mode_switch}, {31'd0, exp_mode});
      check("is_vertical", {31'd0, is_vertical}, {31'd0, exp_vert});
      check("state_wait_frame", {30'd0, o_dbg_state}, 32'd1);
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      exp_line_err  = 1'b0;
      exp_frame_err = 1'b0;
      tick(1);
      check("line_err_cleared", {31'd0, line_err}, 32'd0);
      check("frame_err_cleared", {31'd0, frame_err}, 32'd0);
   endtask

   task automatic clean_frame(input bit gappy);
      frame_start();
      for (int l = 0; l < H; l++) line(W, gappy && (l % 2 == 1), 1'b1, 1'b0, 1'b0);
      frame_end();
   endtask

   task automatic reset_model();
      exp_frames     = 0;
      done_since_rst = 0;
      exp_mode       = 1'b0;
      exp_vert       = 1'b0;
      exp_line_err   = 1'b0;
      exp_frame_err  = 1'b0;
   endtask

   initial begin
      int wait_cnt;
      // Reset held while a frame is already in progress.
      rst   = 1'b0;
      iFVAL = 1'b1;
      tick(3);
      check("rst_x", {21'd0, X_Cont}, 32'd0);
      check("rst_y", {21'd0, Y_Cont}, 32'd0);
      check("rst_dval", {31'd0, oDVAL}, 32'd0);
      check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("rst_mode", {30'd0, mode_switch, is_vertical}, 32'd0);
      check("rst_errs", {29'd0, line_err, frame_err, edge_ready}, 32'd0);
      check("rst_state_sync", {30'd0, o_dbg_state}, 32'd0);
      rst = 1'b1;
      line(W, 1'b0, 1'b0, 1'b0, 1'b0);
      line(W, 1'b0, 1'b0, 1'b0, 1'b0);
      iFVAL = 1'b0;
      tick(4);
      check("sync_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("sync_state_wait", {30'd0, o_dbg_state}, 32'd1);

      // Clean grey frame.
      clean_frame(1'b1);

      // Request edge/vertical mid-frame; it must wait for the next frame.
      frame_start();
      for (int l = 0; l < H; l++) begin
         line(W, 1'b0, 1'b1, 1'b0, 1'b0);
         if (l == 3) begin
            req_mode     = 1'b1;
            req_vertical = 1'b1;
         end
      end
      frame_end();

      // Edge frame with zero-pixel, short and long lines.
      frame_start();
      line(0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int l = 0; l < H; l++) begin
         if (l == 5) begin
            line(W - 1, 1'b0, 1'b1, 1'b0, 1'b0);
            check("short_line_err", {31'd0, line_err}, {31'd0, exp_line_err});
            clear_errors();
         end else if (l == 6) begin
            line(W + 2, 1'b0, 1'b1, 1'b0, 1'b1);
            check("long_line_err_set_wins", {31'd0, line_err}, {31'd0, exp_line_err});
         end else begin
            line(W, 1'b0, 1'b1, 1'b0, 1'b0);
         end
      end
      frame_end();
      clear_errors();

      // Short frame whose last line and frame end together.
      req_vertical = 1'b0;
      frame_start();
      for (int l = 0; l < H - 1; l++) line(W, 1'b0, 1'b1, (l == H - 2), 1'b0);
      frame_end();
      check("short_frame_y_cont", {21'd0, Y_Cont}, 32'(H - 2));
      clear_errors();

      // Reset in the middle of a frame, released while the frame continues.
      req_mode = 1'b0;
      frame_start();
      line(W, 1'b0, 1'b1, 1'b0, 1'b0);
      line(W, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      reset_model();
      tick(2);
      check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("midrst_xy", {10'd0, X_Cont, Y_Cont}, 32'd0);
      check("midrst_state", {30'd0, o_dbg_state}, 32'd0);
      rst = 1'b1;
      line(W, 1'b0, 1'b0, 1'b0, 1'b0);
      iFVAL = 1'b0;
      tick(4);
      check("midrst_resync_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      clean_frame(1'b0);

`ifdef AUTO_CYCLE_EN
      begin
         logic [1:0] auto_tab [6];
         auto_tab = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11};
         rst = 1'b0;
         reset_model();
         tick(2);
         rst = 1'b1;
         req_mode     = 1'b1;
         req_vertical = 1'b1;
         tick(2);
         for (int f = 0; f < 6; f++) begin
            clean_frame(1'b0);
            check("auto_mode_seq", {30'd0, mode_switch, is_vertical}, {30'd0, auto_tab[f]});
         end
      end
`endif

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         tick(1);
         wait_cnt++;
      end
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
